// File: rtl/serial_fft_pkg.sv
// Shared types and helpers for the serial FFT frame controller.
package serial_fft_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        BURST   = 2'd1,
        COLLECT = 2'd2,
        DRAIN   = 2'd3
    } fft_ctrl_state_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frame_reg_buf.sv
// One-frame register array: one write port, one combinational read port.
// Out-of-range read addresses return zero so callers may present a
// one-past-the-end address without side effects.
module frame_reg_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int SEL_W = $clog2(DEPTH);

    logic [WIDTH-1:0] words [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [WIDTH-1:0] word_reg;

        // Load this entry when the write address selects it.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == AW'(gi))) begin
                word_reg <= wr_data;
            end
        end

        assign words[gi] = word_reg;
    end

    assign rd_data = (rd_addr < AW'(DEPTH)) ? words[rd_addr[SEL_W-1:0]] : '0;

endmodule

// File: rtl/serial_fft_frame_ctrl.sv
// Frame sequencer around serial_fft_coral: buffers a frame of sample pairs,
// bursts it into the core contiguously, collects the results and replays
// them downstream under valid/ready backpressure. All outputs registered.
module serial_fft_frame_ctrl
    import serial_fft_pkg::*;
#(
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 32,
    parameter int FRAME_LENGTH = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [X_WIDTH-1:0] s_x1,
    input  logic [X_WIDTH-1:0] s_x2,
    output logic               core_valid_i,
    output logic [X_WIDTH-1:0] core_x1,
    output logic [X_WIDTH-1:0] core_x2,
    input  logic [S_WIDTH-1:0] core_re1,
    input  logic [S_WIDTH-1:0] core_im1,
    input  logic [S_WIDTH-1:0] core_re2,
    input  logic [S_WIDTH-1:0] core_im2,
    input  logic               core_valid_o,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [S_WIDTH-1:0] m_re1,
    output logic [S_WIDTH-1:0] m_im1,
    output logic [S_WIDTH-1:0] m_re2,
    output logic [S_WIDTH-1:0] m_im2,
    output logic               m_last,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_spurious
);

    localparam int CW = CNT_W(FRAME_LENGTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = 2 * X_WIDTH;
    localparam int RW = 4 * S_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LENGTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_LENGTH);
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT);

    fft_ctrl_state_e state_reg, state_next;
    logic [CW-1:0] wcnt_reg, wcnt_next, bcnt_reg, bcnt_next;
    logic [CW-1:0] ccnt_reg, ccnt_next, rcnt_reg, rcnt_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          s_ready_reg, s_ready_next, core_valid_reg, core_valid_next;
    logic [IW-1:0] core_x_reg, core_x_next;
    logic          m_valid_reg, m_valid_next, m_last_reg, m_last_next;
    logic [RW-1:0] m_data_reg, m_data_next;
    logic          busy_reg, busy_next;
    logic          err_timeout_reg, err_timeout_next, err_spurious_reg, err_spurious_next;

    logic [CW-1:0] in_rd_addr, out_rd_addr;
    logic [IW-1:0] in_rd_data;
    logic [RW-1:0] out_rd_data, out_fwd_data, core_res;
    logic          in_hs, cap_ok, cap_en, spurious, out_hs, enter_drain;

    assign core_res = {core_re1, core_im1, core_re2, core_im2};
    assign in_hs    = s_valid && s_ready_reg;
    assign cap_ok   = ((state_reg == BURST) || (state_reg == COLLECT)) && (ccnt_reg != FULL_CNT);
    assign cap_en   = core_valid_o && cap_ok;
    assign spurious = core_valid_o && !cap_ok;
    assign out_hs   = m_valid_reg && m_ready;

    // Read addresses look one beat ahead of the beat currently presented;
    // outside BURST/DRAIN they point at entry 0 for the first beat.
    assign in_rd_addr  = (state_reg == BURST) ? (bcnt_reg + CW'(1)) : '0;
    assign out_rd_addr = (state_reg == DRAIN) ? (rcnt_reg + CW'(1)) : '0;
    // A single-beat frame may enter DRAIN on the very cycle its beat is written.
    assign out_fwd_data = (cap_en && (ccnt_reg == out_rd_addr)) ? core_res : out_rd_data;

    frame_reg_buf #(.WIDTH(IW), .DEPTH(FRAME_LENGTH), .AW(CW)) u_in_buf (
        .clk     (clk),
        .wr_en   (in_hs),
        .wr_addr (wcnt_reg),
        .wr_data ({s_x1, s_x2}),
        .rd_addr (in_rd_addr),
        .rd_data (in_rd_data)
    );

    frame_reg_buf #(.WIDTH(RW), .DEPTH(FRAME_LENGTH), .AW(CW)) u_out_buf (
        .clk     (clk),
        .wr_en   (cap_en),
        .wr_addr (ccnt_reg),
        .wr_data (core_res),
        .rd_addr (out_rd_addr),
        .rd_data (out_rd_data)
    );

    // Next-state, counter and registered-output logic for the frame FSM.
    always_comb begin
        state_next        = state_reg;
        wcnt_next         = wcnt_reg;
        bcnt_next         = bcnt_reg;
        ccnt_next         = cap_en ? (ccnt_reg + CW'(1)) : ccnt_reg;
        rcnt_next         = rcnt_reg;
        timer_next        = timer_reg;
        core_valid_next   = core_valid_reg;
        core_x_next       = core_x_reg;
        m_valid_next      = m_valid_reg;
        m_data_next       = m_data_reg;
        m_last_next       = m_last_reg;
        err_timeout_next  = err_timeout_reg;
        err_spurious_next = err_spurious_reg | spurious;
        enter_drain       = 1'b0;

        case (state_reg)
            FILL: begin
                if (in_hs) begin
                    if (wcnt_reg == LAST_IDX) begin
                        state_next      = BURST;
                        wcnt_next       = '0;
                        bcnt_next       = '0;
                        core_valid_next = 1'b1;
                        core_x_next     = in_rd_data;
                    end else begin
                        wcnt_next = wcnt_reg + CW'(1);
                    end
                end
            end
            BURST: begin
                if (bcnt_reg == LAST_IDX) begin
                    state_next      = COLLECT;
                    bcnt_next       = '0;
                    timer_next      = '0;
                    core_valid_next = 1'b0;
                    core_x_next     = '0;
                end else begin
                    bcnt_next   = bcnt_reg + CW'(1);
                    core_x_next = in_rd_data;
                end
            end
            COLLECT: begin
                if (timer_reg != TMO) begin
                    timer_next = timer_reg + TW'(1);
                end
                if (ccnt_next == FULL_CNT) begin
                    enter_drain = 1'b1;
                end else if (timer_reg == TMO) begin
                    err_timeout_next = 1'b1;
                    if (ccnt_next != '0) begin
                        enter_drain = 1'b1;
                    end else begin
                        state_next = FILL;
                        timer_next = '0;
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (m_last_reg) begin
                        state_next   = FILL;
                        rcnt_next    = '0;
                        ccnt_next    = '0;
                        m_valid_next = 1'b0;
                        m_data_next  = '0;
                        m_last_next  = 1'b0;
                    end else begin
                        rcnt_next   = rcnt_reg + CW'(1);
                        m_data_next = out_fwd_data;
                        m_last_next = ((rcnt_reg + CW'(1)) == (ccnt_reg - CW'(1)));
                    end
                end
            end
            default: state_next = FILL;
        endcase

        if (enter_drain) begin
            state_next   = DRAIN;
            timer_next   = '0;
            rcnt_next    = '0;
            m_valid_next = 1'b1;
            m_data_next  = out_fwd_data;
            m_last_next  = (ccnt_next == CW'(1));
        end

        s_ready_next = (state_next == FILL);
        busy_next    = (state_next != FILL) || (wcnt_next != '0);
    end

    // State, counters and outputs; async reset discards any frame in flight.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg        <= FILL;
            wcnt_reg         <= '0;
            bcnt_reg         <= '0;
            ccnt_reg         <= '0;
            rcnt_reg         <= '0;
            timer_reg        <= '0;
            s_ready_reg      <= 1'b0;
            core_valid_reg   <= 1'b0;
            core_x_reg       <= '0;
            m_valid_reg      <= 1'b0;
            m_data_reg       <= '0;
            m_last_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            err_timeout_reg  <= 1'b0;
            err_spurious_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wcnt_reg         <= wcnt_next;
            bcnt_reg         <= bcnt_next;
            ccnt_reg         <= ccnt_next;
            rcnt_reg         <= rcnt_next;
            timer_reg        <= timer_next;
            s_ready_reg      <= s_ready_next;
            core_valid_reg   <= core_valid_next;
            core_x_reg       <= core_x_next;
            m_valid_reg      <= m_valid_next;
            m_data_reg       <= m_data_next;
            m_last_reg       <= m_last_next;
            busy_reg         <= busy_next;
            err_timeout_reg  <= err_timeout_next;
            err_spurious_reg <= err_spurious_next;
        end
    end

    assign s_ready                          = s_ready_reg;
    assign core_valid_i                     = core_valid_reg;
    assign {core_x1, core_x2}               = core_x_reg;
    assign m_valid                          = m_valid_reg;
    assign {m_re1, m_im1, m_re2, m_im2}     = m_data_reg;
    assign m_last                           = m_last_reg;
    assign busy                             = busy_reg;
    assign err_timeout                      = err_timeout_reg;
    assign err_spurious                     = err_spurious_reg;

endmodule
